// File: rtl/quadarb_pkg.sv
// Shared types and constants for the quadarb4 round-robin nibble arbiter.
package quadarb_pkg;
    localparam int NUM_SRC = 4;

    typedef logic [1:0] sel_t;

    localparam sel_t LAST_RST = 2'd3;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;
endpackage

// File: rtl/quadarb4_if.sv
// Request/grant, mux select/sample and output valid/ready bundle of quadarb4.
interface quadarb4_if #(
    parameter int WIDTH = 4
);
    logic [3:0]       req;
    logic [3:0]       gnt;
    logic [1:0]       S;
    logic [WIDTH-1:0] mux_out;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_src;

    modport master (
        input  req, mux_out, out_ready,
        output gnt, S, out_valid, out_data, out_src
    );

    modport slave (
        output req, mux_out, out_ready,
        input  gnt, S, out_valid, out_data, out_src
    );
endinterface

// File: rtl/quadarb4_rr_pick4.sv
// rr_pick4: combinational round-robin search starting one past the last winner.
module rr_pick4
    import quadarb_pkg::*;
(
    input  logic [NUM_SRC-1:0] req,
    input  sel_t               last,
    output sel_t               winner,
    output logic               any
);
    sel_t idx;
    logic found;

    always_comb begin
        winner = last;
        found  = 1'b0;
        idx    = last;
        any    = |req;
        // Offset NUM_SRC wraps back to last itself, giving it lowest priority.
        for (int k = 1; k <= NUM_SRC; k++) begin
            idx = last + sel_t'(k);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end
endmodule

// File: rtl/quadarb4.sv
// quadarb4: fair 4:1 nibble funnel driving a quad mux select with a one-entry output buffer.
// Optional QUADARB_LOCK_EN adds a lock input that lets the last winner keep the grant.
module quadarb4
    import quadarb_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic rst,
`ifdef QUADARB_LOCK_EN
    input  logic lock,
`endif
    quadarb4_if.master bus
);
    state_t           stateQ;
    state_t           stateNxt;
    sel_t             lastQ;
    sel_t             sHoldQ;
    sel_t             srcQ;
    sel_t             rrWinner;
    sel_t             winner;
    logic [WIDTH-1:0] dataQ;
    logic             anyReq;
    logic             accept;
    logic             grantEn;

    rr_pick4 uPick (
        .req    (bus.req),
        .last   (lastQ),
        .winner (rrWinner),
        .any    (anyReq)
    );

`ifdef QUADARB_LOCK_EN
    assign winner = (lock && bus.req[lastQ]) ? lastQ : rrWinner;
`else
    assign winner = rrWinner;
`endif

    // Drain and refill in one cycle keeps throughput at one nibble per clock.
    assign accept  = (stateQ == EMPTY) || bus.out_ready;
    assign grantEn = accept && anyReq && !rst;

    always_comb begin
        stateNxt = stateQ;
        bus.gnt  = '0;
        bus.S    = sHoldQ;
        if (grantEn) begin
            bus.gnt[winner] = 1'b1;
            bus.S           = winner;
            stateNxt        = FULL;
        end else if (accept) begin
            stateNxt = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ <= EMPTY;
            lastQ  <= LAST_RST;
            sHoldQ <= '0;
            srcQ   <= '0;
            dataQ  <= '0;
        end else begin
            stateQ <= stateNxt;
            if (grantEn) begin
                lastQ  <= winner;
                sHoldQ <= winner;
                srcQ   <= winner;
                dataQ  <= bus.mux_out;
            end
        end
    end

    assign bus.out_valid = (stateQ == FULL);
    assign bus.out_data  = dataQ;
    assign bus.out_src   = srcQ;
endmodule

// File: tb/tb_quadarb4.sv
// Directed bench for quadarb4 with a behavioural quad mux and a scoreboard queue.
module tb_quadarb4;
    typedef struct packed {
        logic [1:0] src;
        logic [3:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       tbLock;
    logic [3:0] din [4];
    exp_t       sb [$];

    int nVec = 0;
    int nErr = 0;

    logic [1:0] mLast;
    logic [1:0] mS;
    logic       mValid;
    logic [3:0] mData;
    logic [1:0] mSrc;

    quadarb4_if #(.WIDTH(4)) bus ();

    assign bus.mux_out = din[bus.S];

    quadarb4 #(.WIDTH(4)) dut (
        .clk  (clk),
        .rst  (rst),
`ifdef QUADARB_LOCK_EN
        .lock (tbLock),
`endif
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        nVec++;
        assert (obs === expv)
        else begin
            nErr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [1:0] pickModel(input logic [3:0] r, input logic [1:0] last,
                                             input logic lk);
        int i;
`ifdef QUADARB_LOCK_EN
        if (lk && r[last]) return last;
`else
        if (lk && 1'b0) return last;
`endif
        for (int k = 1; k <= 4; k++) begin
            i = (int'(last) + k) % 4;
            if (r[i]) return 2'(i);
        end
        return last;
    endfunction

    // One clock: drive, check combinational grant/select, then check registered outputs.
    task automatic cycle(input logic [3:0] r, input logic rdy, input string tag);
        logic       acc;
        logic       g;
        logic [1:0] w;
        exp_t       e;
        bus.req       = r;
        bus.out_ready = rdy;
        #1;
        acc = !mValid || rdy;
        g   = acc && (r != 4'b0);
        w   = pickModel(r, mLast, tbLock);
        chk({tag, ".gnt"}, {4'b0, bus.gnt}, g ? (8'd1 << w) : 8'd0);
        chk({tag, ".S"}, {6'b0, bus.S}, {6'b0, (g ? w : mS)});
        if (g) sb.push_back('{src: w, data: din[w]});
        @(posedge clk);
        #1;
        if (g) begin
            mLast  = w;
            mS     = w;
            mValid = 1'b1;
            if (sb.size() == 0) begin
                nVec++;
                nErr++;
                $display("FAIL %s.sb observed=empty expected=entry", tag);
            end else begin
                e     = sb.pop_front();
                mData = e.data;
                mSrc  = e.src;
            end
        end else if (acc) begin
            mValid = 1'b0;
        end
        chk({tag, ".valid"}, {7'b0, bus.out_valid}, {7'b0, mValid});
        chk({tag, ".data"}, {4'b0, bus.out_data}, {4'b0, mData});
        chk({tag, ".src"}, {6'b0, bus.out_src}, {6'b0, mSrc});
    endtask

    task automatic modelReset();
        mLast  = 2'd3;
        mS     = 2'd0;
        mValid = 1'b0;
        mData  = 4'h0;
        mSrc   = 2'd0;
        sb.delete();
    endtask

    initial begin
        rst           = 1'b1;
        tbLock        = 1'b0;
        bus.req       = 4'b0;
        bus.out_ready = 1'b0;
        din[0] = 4'h3; din[1] = 4'h5; din[2] = 4'h9; din[3] = 4'hC;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst.valid", {7'b0, bus.out_valid}, 8'h0);
        chk("rst.data", {4'b0, bus.out_data}, 8'h0);
        chk("rst.src", {6'b0, bus.out_src}, 8'h0);
        chk("rst.gnt", {4'b0, bus.gnt}, 8'h0);
        chk("rst.S", {6'b0, bus.S}, 8'h0);
        rst = 1'b0;

        // Full request with free-flowing output rotates 0,1,2,3,0.
        for (int i = 0; i < 5; i++) cycle(4'b1111, 1'b1, "rot");
        cycle(4'b0000, 1'b1, "drain1");

        din[2] = 4'hA;
        cycle(4'b0100, 1'b1, "solo2");

        // Backpressure: grants withheld, buffer stable, then rotation from last.
        for (int i = 0; i < 3; i++) cycle(4'b0011, 1'b0, "stall");
        cycle(4'b0011, 1'b1, "release");
        cycle(4'b0000, 1'b1, "drain2");
        cycle(4'b0000, 1'b0, "idle");

        // Reset while the buffer is full.
        din[0] = 4'h6; din[1] = 4'hE; din[3] = 4'h1;
        cycle(4'b1010, 1'b1, "prefill");
        cycle(4'b1010, 1'b0, "prefill2");
        rst           = 1'b1;
        bus.req       = 4'b1111;
        bus.out_ready = 1'b1;
        #1;
        chk("midrst.gnt", {4'b0, bus.gnt}, 8'h0);
        @(posedge clk);
        #1;
        modelReset();
        chk("midrst.valid", {7'b0, bus.out_valid}, 8'h0);
        chk("midrst.data", {4'b0, bus.out_data}, 8'h0);
        rst = 1'b0;
        cycle(4'b1001, 1'b1, "post0");
        cycle(4'b1001, 1'b1, "post1");

        for (int i = 0; i < 24; i++) begin
            din[i % 4] = 4'($urandom_range(15, 0));
            cycle(4'($urandom_range(15, 0)), 1'($urandom_range(1, 0)), "rand");
        end

`ifdef QUADARB_LOCK_EN
        tbLock = 1'b1;
        for (int i = 0; i < 4; i++) cycle(4'b1111, 1'b1, "lock");
        tbLock = 1'b0;
        for (int i = 0; i < 3; i++) cycle(4'b1111, 1'b1, "unlock");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end
endmodule

// File: doc/quadarb4.md
# quadarb4

Four-requester round-robin arbiter that sits directly upstream of the 4-bit quad 4:1 mux. It drives the mux's 2-bit select `S`, samples the mux's `Out` back in, and registers the selected nibble into a one-entry output buffer with a valid/ready handshake to the downstream consumer. It turns the combinational mux into a fair, flow-controlled 4:1 nibble funnel.

## Interface
- `WIDTH`, 4: data width; must equal the quad mux width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  4  request per source; bit i corresponds to mux input A/B/C/D for i=0/1/2/3.
- `gnt`  out  4  one-hot grant pulse; `gnt[i]`=1 for exactly the cycle source i's data is captured.
- `S`  out  2  select to the quad mux.
- `mux_out`  in  WIDTH  the quad mux `Out`, combinationally dependent on `S`.
- `out_valid`  out  1  output buffer holds data.
- `out_ready`  in  1  downstream accepts data this cycle.
- `out_data`  out  WIDTH  buffered nibble.
- `out_src`  out  2  index of the source that produced `out_data`.
- `lock`  in  1  present only with `QUADARB_LOCK_EN`; see Configuration.

## Operation
- Round-robin pointer `last` (2 bits) holds the index of the most recent winner.
- Winner search order: `last+1`, `last+2`, `last+3`, `last` (mod 4); first set `req` bit wins.
- Buffer can accept when `!out_valid || out_ready` (`accept`).
- In a cycle with `accept` and `|req`: `S` = winner (combinational), `gnt[winner]`=1, and at the edge `out_data`<=`mux_out`, `out_src`<=winner, `out_valid`<=1, `last`<=winner.
- If `accept` and `req`==0: `gnt`=0, `S` holds its previous value, `out_valid`<=0 if it was drained.
- If `!accept`: `gnt`=0, `S` holds, buffer and `last` unchanged; `req` is ignored and no data is lost, because sources hold `req` until granted.
- Drain and refill in the same cycle (`out_valid && out_ready && |req`) is required, giving one transfer per cycle.
- Two states, EMPTY (`out_valid`=0) and FULL (`out_valid`=1):
  - EMPTY->FULL on grant.
  - FULL->FULL on a grant with `out_ready`, or on stall.
  - FULL->EMPTY on `out_ready` with no `req`.
- Starvation bound: a continuously requesting source is granted within 4 grants.

## Timing
- Grant decision and `S` are combinational from `req`, `last`, `out_valid`, and `out_ready`.
- The `S`->`mux_out` path closes in the same cycle.
- Latency: request granted in cycle N appears on `out_data` with `out_valid`=1 in cycle N+1.
- Reset values: `out_valid`=0, `out_data`=0, `out_src`=0, `gnt`=0, `S`=0, `last`=3, so source 0 has first priority after reset.
- Reset asserted mid-operation discards the buffered data and clears `gnt` in the reset cycle; no grant is issued while `rst`=1.
- `out_data`, `out_src`, and `out_valid` are register outputs with no combinational path from `out_ready`.

## Configuration
- `QUADARB_LOCK_EN` defined:
  - The `lock` port exists.
  - If `lock`=1 and `req[last]`=1 at a grant opportunity, source `last` wins again regardless of rotation.
  - With `lock`=0, behaviour is pure round-robin.
- Undefined: no `lock` port; pure round-robin.

## Structure
- Package `quadarb_pkg`:
  - `NUM_SRC`=4.
  - `sel_t` (2-bit select type).
  - Reset constant `LAST_RST`=2'd3.
- One sub-module, `rr_pick4`: combinational; inputs `req[3:0]` and `last`; outputs `winner` (`sel_t`) and `any`.
- The top holds the buffer, the pointer, and the `S` hold register.

## Test plan
- Reset, then `req`=4'b1111 held with `out_ready`=1 -> grants 0,1,2,3,0 on consecutive cycles; `out_src` follows one cycle later; `out_data` equals the InA..InD nibbles driven into the mux.
- `req`=4'b0100 only, `mux_out` tied via mux with InC=4'hA -> `S`=2, `gnt`=4'b0100, next cycle `out_data`=4'hA, `out_valid`=1.
- Buffer full, `out_ready`=0 for 3 cycles with `req`=4'b0011 -> `gnt`=0 and `out_data` stable throughout; on `out_ready`=1 the next grant goes to the source after `last`.
- `out_valid`=1, `out_ready`=1, `req`=0 -> `out_valid`=0 next cycle and `S` unchanged.
- `rst` asserted while `out_valid`=1 -> next cycle `out_valid`=0 and `last`=3; then `req`=4'b1001 -> source 0 granted first.
- With `QUADARB_LOCK_EN`, `lock`=1, `req`=4'b1111 -> the same source is granted every cycle; deassert `lock` -> rotation resumes from that source+1.
